// File: rtl/regex_cpu_core_pkg.sv
// Shared definitions for the regex coprocessor: instruction encoding,
// opcode enumeration and the thread-execution state encodings.
package regex_cpu_core_pkg;

   localparam int OPCODE_WIDTH           = 3;
   localparam int INSTRUCTION_DATA_WIDTH = 13;
   localparam int INSTRUCTION_WIDTH      = OPCODE_WIDTH + INSTRUCTION_DATA_WIDTH;

   typedef enum logic [OPCODE_WIDTH-1:0] {
      ACCEPT                = 3'b000,
      SPLIT                 = 3'b001,
      MATCH                 = 3'b010,
      JMP                   = 3'b011,
      END_WITHOUT_ACCEPTING = 3'b100,
      MATCH_ANY             = 3'b101,
      ACCEPT_PARTIAL        = 3'b110,
      NOT_MATCH             = 3'b111
   } opcode_e;

   typedef struct packed {
      opcode_e                           opcode;
      logic [INSTRUCTION_DATA_WIDTH-1:0] data;
   } instruction_t;

   // Thread execution states; plain constants so older tools can consume them.
   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_FETCH     = 3'd1;
   localparam logic [2:0] S_WAIT_DATA = 3'd2;
   localparam logic [2:0] S_EXEC      = 3'd3;
   localparam logic [2:0] S_OUT1      = 3'd4;
   localparam logic [2:0] S_OUT2      = 3'd5;

   function automatic instruction_t unpack_instruction(input logic [INSTRUCTION_WIDTH-1:0] word);
      return instruction_t'(word);
   endfunction

endpackage

// File: rtl/regex_cpu_core.sv
// Single-thread regex execution unit: takes one (pc, cc_id) thread, fetches
// its instruction, executes it against the current character windows and
// emits up to two successor threads or a one-cycle accept pulse.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// S_IDLE      | ready for a new thread from the scheduler
// S_FETCH     | instruction request held on the memory port until accepted
// S_WAIT_DATA | memory accepted; instruction word arrives this cycle
// S_EXEC      | decode/execute; accept pulse lives only here
// S_OUT1      | first (or only) successor presented until taken
// S_OUT2      | second successor of a SPLIT presented until taken
module regex_cpu_core
   import regex_cpu_core_pkg::*;
#(
   parameter int PC_WIDTH          = 9,
   parameter int CC_ID_BITS        = 1,
   parameter int CHARACTER_WIDTH   = 8,
   parameter int MEMORY_WIDTH      = 16,
   parameter int MEMORY_ADDR_WIDTH = 11
) (
   input  logic                                        clk,
   input  logic                                        rst,
   input  logic [(2**CC_ID_BITS)*CHARACTER_WIDTH-1:0]  current_characters,
   input  logic [2**CC_ID_BITS-1:0]                    end_of_string,
   input  logic                                        input_pc_valid,
   output logic                                        input_pc_ready,
   input  logic [CC_ID_BITS-1:0]                       input_cc_id,
   input  logic [PC_WIDTH-1:0]                         input_pc,
   output logic                                        memory_valid,
   output logic [MEMORY_ADDR_WIDTH-1:0]                memory_addr,
   input  logic                                        memory_ready,
   input  logic [MEMORY_WIDTH-1:0]                     memory_data,
   output logic                                        output_pc_valid,
   input  logic                                        output_pc_ready,
   output logic [PC_WIDTH-1:0]                         output_pc,
   output logic [CC_ID_BITS-1:0]                       output_cc_id,
   output logic                                        accepts
);

   localparam int NUM_WINDOWS = 2**CC_ID_BITS;

   logic [2:0]            state_q,   state_d;
   logic [PC_WIDTH-1:0]   pc_q,      pc_d;
   logic [CC_ID_BITS-1:0] cc_q,      cc_d;
   instruction_t          instr_q,   instr_d;
   logic [PC_WIDTH-1:0]   out1_pc_q, out1_pc_d;
   logic [CC_ID_BITS-1:0] out1_cc_q, out1_cc_d;
   logic [PC_WIDTH-1:0]   out2_pc_q, out2_pc_d;
   logic [CC_ID_BITS-1:0] out2_cc_q, out2_cc_d;
   logic                  second_q,  second_d;

   logic [CHARACTER_WIDTH-1:0] exec_char;
   logic                       exec_eos;
   logic                       exec_accept;
   logic                       exec_emit;
   logic                       exec_second;
   logic [PC_WIDTH-1:0]        exec_pc;
   logic [CC_ID_BITS-1:0]      exec_cc;
   logic [PC_WIDTH-1:0]        pc_plus1;
   logic [CC_ID_BITS-1:0]      cc_plus1;
   logic [PC_WIDTH-1:0]        target;
   logic [CHARACTER_WIDTH-1:0] data_char;
   logic                       unused_instr_bits;

   assign pc_plus1  = pc_q + PC_WIDTH'(1);
   assign cc_plus1  = cc_q + CC_ID_BITS'(1);
   assign target    = instr_q.data[PC_WIDTH-1:0];
   assign data_char = instr_q.data[CHARACTER_WIDTH-1:0];
   assign exec_eos  = end_of_string[cc_q];

   // Only the low bits of the payload carry meaning for any opcode.
   assign unused_instr_bits = ^instr_q;

   // Pick the character window addressed by the thread's cc_id.
   always_comb begin
      exec_char = '0;
      for (int i = 0; i < NUM_WINDOWS; i++) begin
         if (cc_q == CC_ID_BITS'(i)) begin
            exec_char = current_characters[i*CHARACTER_WIDTH +: CHARACTER_WIDTH];
         end
      end
   end

   // Instruction decode: accept condition and first successor thread.
   always_comb begin
      exec_accept = 1'b0;
      exec_emit   = 1'b0;
      exec_second = 1'b0;
      exec_pc     = pc_plus1;
      exec_cc     = cc_q;
      case (instr_q.opcode)
         ACCEPT: begin
            exec_accept = exec_eos;
         end
         SPLIT: begin
            exec_emit   = 1'b1;
            exec_second = 1'b1;
         end
         MATCH: begin
            exec_emit = !exec_eos && (exec_char == data_char);
            exec_cc   = cc_plus1;
         end
         JMP: begin
            exec_emit = 1'b1;
            exec_pc   = target;
         end
         END_WITHOUT_ACCEPTING: begin
            exec_emit = 1'b0;
         end
         MATCH_ANY: begin
            exec_emit = !exec_eos;
            exec_cc   = cc_plus1;
         end
         ACCEPT_PARTIAL: begin
            exec_accept = 1'b1;
         end
         NOT_MATCH: begin
            exec_emit = !exec_eos && (exec_char != data_char);
            exec_cc   = cc_plus1;
         end
         default: begin
            exec_emit = 1'b0;
         end
      endcase
   end

   // Next-state logic and capture of thread, instruction and successors.
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      cc_d      = cc_q;
      instr_d   = instr_q;
      out1_pc_d = out1_pc_q;
      out1_cc_d = out1_cc_q;
      out2_pc_d = out2_pc_q;
      out2_cc_d = out2_cc_q;
      second_d  = second_q;
      case (state_q)
         S_IDLE: begin
            if (input_pc_valid) begin
               pc_d    = input_pc;
               cc_d    = input_cc_id;
               state_d = S_FETCH;
            end
         end
         S_FETCH: begin
            if (memory_ready) begin
               state_d = S_WAIT_DATA;
            end
         end
         S_WAIT_DATA: begin
            instr_d = unpack_instruction(memory_data[INSTRUCTION_WIDTH-1:0]);
            state_d = S_EXEC;
         end
         S_EXEC: begin
            // Successors are frozen here so they stay stable while the
            // character windows move on underneath a stalled output.
            out1_pc_d = exec_pc;
            out1_cc_d = exec_cc;
            out2_pc_d = target;
            out2_cc_d = cc_q;
            second_d  = exec_second;
            state_d   = exec_emit ? S_OUT1 : S_IDLE;
         end
         S_OUT1: begin
            if (output_pc_ready) begin
               state_d = second_q ? S_OUT2 : S_IDLE;
            end
         end
         S_OUT2: begin
            if (output_pc_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         pc_q      <= '0;
         cc_q      <= '0;
         instr_q   <= '0;
         out1_pc_q <= '0;
         out1_cc_q <= '0;
         out2_pc_q <= '0;
         out2_cc_q <= '0;
         second_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         cc_q      <= cc_d;
         instr_q   <= instr_d;
         out1_pc_q <= out1_pc_d;
         out1_cc_q <= out1_cc_d;
         out2_pc_q <= out2_pc_d;
         out2_cc_q <= out2_cc_d;
         second_q  <= second_d;
      end
   end

   // Outputs are forced low while reset is held, whatever the state register holds.
   always_comb begin
      input_pc_ready  = rst && (state_q == S_IDLE);
      memory_valid    = rst && (state_q == S_FETCH);
      memory_addr     = rst ? MEMORY_ADDR_WIDTH'(pc_q) : '0;
      output_pc_valid = rst && ((state_q == S_OUT1) || (state_q == S_OUT2));
      output_pc       = '0;
      output_cc_id    = '0;
      if (output_pc_valid) begin
         output_pc    = (state_q == S_OUT2) ? out2_pc_q : out1_pc_q;
         output_cc_id = (state_q == S_OUT2) ? out2_cc_q : out1_cc_q;
      end
      accepts = rst && (state_q == S_EXEC) && exec_accept;
   end

endmodule

// File: tb/tb_regex_cpu_core.sv
// Directed bench for regex_cpu_core: reset behaviour, dead threads, each
// opcode's successor/accept behaviour, output back-pressure and pc wrap.
module tb_regex_cpu_core;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] current_characters;
   logic [1:0]  end_of_string;
   logic        input_pc_valid;
   logic        input_pc_ready;
   logic        input_cc_id;
   logic [8:0]  input_pc;
   logic        memory_valid;
   logic [10:0] memory_addr;
   logic        memory_ready;
   logic [15:0] memory_data;
   logic        output_pc_valid;
   logic        output_pc_ready;
   logic [8:0]  output_pc;
   logic        output_cc_id;
   logic        accepts;

   int checks   = 0;
   int failures = 0;

   regex_cpu_core dut (
      .clk                (clk),
      .rst                (rst),
      .current_characters (current_characters),
      .end_of_string      (end_of_string),
      .input_pc_valid     (input_pc_valid),
      .input_pc_ready     (input_pc_ready),
      .input_cc_id        (input_cc_id),
      .input_pc           (input_pc),
      .memory_valid       (memory_valid),
      .memory_addr        (memory_addr),
      .memory_ready       (memory_ready),
      .memory_data        (memory_data),
      .output_pc_valid    (output_pc_valid),
      .output_pc_ready    (output_pc_ready),
      .output_pc          (output_pc),
      .output_cc_id       (output_cc_id),
      .accepts            (accepts)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Drives one thread through FETCH and WAIT_DATA; returns at the negedge inside EXEC.
   task automatic run_instr(input logic [8:0] pc, input logic cc,
                            input logic [15:0] ins, input int stall);
      @(negedge clk);
      chk("ready_idle", input_pc_ready, 1);
      input_pc_valid = 1'b1;
      input_pc       = pc;
      input_cc_id    = cc;
      cyc();
      input_pc_valid = 1'b0;
      input_pc       = 9'h0AA;
      chk("ready_fetch", input_pc_ready, 0);
      chk("mem_valid", memory_valid, 1);
      chk("mem_addr", memory_addr, {23'd0, pc});
      for (int s = 0; s < stall; s++) begin
         cyc();
         chk("mem_valid_stall", memory_valid, 1);
         chk("mem_addr_stall", memory_addr, {23'd0, pc});
      end
      memory_ready = 1'b1;
      cyc();
      memory_ready = 1'b0;
      memory_data  = ins;
      chk("mem_valid_wait", memory_valid, 0);
      cyc();
      memory_data = 16'hDEAD;
      chk("out_valid_exec", output_pc_valid, 0);
   endtask

   initial begin
      rst                = 1'b0;
      current_characters = 16'h0000;
      end_of_string      = 2'b00;
      input_pc_valid     = 1'b0;
      input_cc_id        = 1'b0;
      input_pc           = 9'h000;
      memory_ready       = 1'b0;
      memory_data        = 16'h0000;
      output_pc_ready    = 1'b0;

      // Reset held: every output low.
      repeat (3) cyc();
      chk("rst_ready", input_pc_ready, 0);
      chk("rst_mem_valid", memory_valid, 0);
      chk("rst_out_valid", output_pc_valid, 0);
      chk("rst_accepts", accepts, 0);
      rst = 1'b1;
      #1;
      chk("ready_after_release", input_pc_ready, 1);
      for (int i = 0; i < 30; i++) begin
         cyc();
         chk("idle_ready", input_pc_ready, 1);
         chk("idle_mem_valid", memory_valid, 0);
         chk("idle_out_valid", output_pc_valid, 0);
         chk("idle_accepts", accepts, 0);
      end

      // Dead threads: END_WITHOUT_ACCEPTING over a spread of pc/char/payload.
      for (int k = 0; k < 8; k++) begin
         logic [8:0]  pc;
         logic [7:0]  ch;
         logic [4:0]  pl;
         pc = 9'(k * 37);
         ch = 8'((k * 9) % 64);
         pl = 5'((k * 5) % 32);
         current_characters = {8'h00, ch};
         run_instr(pc, 1'b0, {3'b100, 8'd0, pl}, k % 2);
         chk("end_accepts", accepts, 0);
         for (int c = 0; c < 10; c++) begin
            cyc();
            chk("end_ready", input_pc_ready, 1);
            chk("end_out_valid", output_pc_valid, 0);
         end
      end

      // MATCH 'a' against 'a': successor (6, cc 1).
      current_characters = {8'h00, 8'h61};
      end_of_string      = 2'b00;
      run_instr(9'd5, 1'b0, {3'b010, 13'h0061}, 0);
      chk("match_accepts", accepts, 0);
      cyc();
      chk("match_valid", output_pc_valid, 1);
      chk("match_pc", output_pc, 6);
      chk("match_cc", output_cc_id, 1);
      chk("match_ready_busy", input_pc_ready, 0);
      output_pc_ready = 1'b1;
      cyc();
      output_pc_ready = 1'b0;
      chk("match_done_valid", output_pc_valid, 0);
      chk("match_done_ready", input_pc_ready, 1);

      // MATCH 'a' against 'b': thread dies.
      current_characters = {8'h00, 8'h62};
      run_instr(9'd5, 1'b0, {3'b010, 13'h0061}, 0);
      cyc();
      chk("mismatch_valid", output_pc_valid, 0);
      chk("mismatch_ready", input_pc_ready, 1);

      // MATCH with end of string on its window: dies even if char matches.
      current_characters = {8'h00, 8'h61};
      end_of_string      = 2'b01;
      run_instr(9'd5, 1'b0, {3'b010, 13'h0061}, 0);
      cyc();
      chk("match_eos_valid", output_pc_valid, 0);
      end_of_string = 2'b00;

      // SPLIT: (11,0) held through 3 stalled cycles, then (40,0).
      run_instr(9'd10, 1'b0, {3'b001, 13'd40}, 1);
      for (int c = 0; c < 4; c++) begin
         cyc();
         chk("split1_valid", output_pc_valid, 1);
         chk("split1_pc", output_pc, 11);
         chk("split1_cc", output_cc_id, 0);
      end
      output_pc_ready = 1'b1;
      cyc();
      chk("split2_valid", output_pc_valid, 1);
      chk("split2_pc", output_pc, 40);
      chk("split2_cc", output_cc_id, 0);
      cyc();
      output_pc_ready = 1'b0;
      chk("split_done_valid", output_pc_valid, 0);
      chk("split_done_ready", input_pc_ready, 1);

      // ACCEPT at end of string: single-cycle pulse, no output.
      end_of_string = 2'b01;
      run_instr(9'd3, 1'b0, {3'b000, 13'h1234}, 0);
      chk("accept_pulse", accepts, 1);
      cyc();
      chk("accept_pulse_end", accepts, 0);
      chk("accept_out_valid", output_pc_valid, 0);
      chk("accept_ready", input_pc_ready, 1);

      // ACCEPT before end of string: nothing.
      end_of_string = 2'b00;
      run_instr(9'd3, 1'b0, {3'b000, 13'h1234}, 0);
      chk("accept_noeos", accepts, 0);
      cyc();
      chk("accept_noeos_valid", output_pc_valid, 0);
      chk("accept_noeos_ready", input_pc_ready, 1);

      // ACCEPT_PARTIAL pulses regardless of end of string.
      run_instr(9'd4, 1'b1, {3'b110, 13'h0000}, 0);
      chk("partial_pulse", accepts, 1);
      cyc();
      chk("partial_pulse_end", accepts, 0);
      chk("partial_out_valid", output_pc_valid, 0);

      // JMP 0x1FF at pc 0x1FF.
      output_pc_ready = 1'b1;
      run_instr(9'h1FF, 1'b0, {3'b011, 13'h01FF}, 0);
      cyc();
      chk("jmp_valid", output_pc_valid, 1);
      chk("jmp_pc", output_pc, 9'h1FF);
      chk("jmp_cc", output_cc_id, 0);
      cyc();
      chk("jmp_done", output_pc_valid, 0);

      // MATCH_ANY at pc 0x1FF, cc 1: both pc and cc_id wrap.
      run_instr(9'h1FF, 1'b1, {3'b101, 13'h0000}, 0);
      cyc();
      chk("any_valid", output_pc_valid, 1);
      chk("any_pc", output_pc, 9'h000);
      chk("any_cc", output_cc_id, 0);
      cyc();
      chk("any_done", output_pc_valid, 0);

      // MATCH_ANY with end of string on window 1: dies.
      end_of_string = 2'b10;
      run_instr(9'd7, 1'b1, {3'b101, 13'h0000}, 0);
      cyc();
      chk("any_eos_valid", output_pc_valid, 0);
      end_of_string = 2'b00;

      // NOT_MATCH on window 1 ('x'): 'y' passes, 'x' dies.
      current_characters = {8'h78, 8'h79};
      run_instr(9'd20, 1'b1, {3'b111, 13'h0079}, 0);
      cyc();
      chk("notm_valid", output_pc_valid, 1);
      chk("notm_pc", output_pc, 21);
      chk("notm_cc", output_cc_id, 0);
      cyc();
      run_instr(9'd20, 1'b1, {3'b111, 13'h0078}, 0);
      cyc();
      chk("notm_fail_valid", output_pc_valid, 0);
      output_pc_ready = 1'b0;

      // Reset asserted while presenting an output forces outputs low.
      run_instr(9'd7, 1'b0, {3'b011, 13'd99}, 0);
      cyc();
      chk("pre_rst_valid", output_pc_valid, 1);
      rst = 1'b0;
      #1;
      chk("midrst_valid", output_pc_valid, 0);
      chk("midrst_pc", output_pc, 0);
      chk("midrst_ready", input_pc_ready, 0);
      cyc();
      rst = 1'b1;
      #1;
      chk("post_rst_ready", input_pc_ready, 1);
      chk("post_rst_valid", output_pc_valid, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
